// File: rtl/imem_boot_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_boot_loader_if : byte-stream and instruction-memory write bundle
// Revision 1.0
// ---------------------------------------------------------------------------
interface imem_boot_loader_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  rx_valid;
   logic [7:0]            rx_data;
   logic                  rx_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;

   // master: byte source plus memory sink; slave: the loader itself
   modport master (
      output rx_valid, rx_data,
      input  rx_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  rx_valid, rx_data,
      output rx_ready, imem_we, imem_addr, imem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_boot_loader : length-prefixed byte stream -> big-endian instruction words
// Revision 1.0
// ---------------------------------------------------------------------------
module imem_boot_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  wire               clk,
   input  wire               rst,
   input  wire               start,
   imem_boot_loader_if.slave bus,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error
);
   localparam logic [16:0] c_DEPTH = 17'(2 ** ADDR_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HDR_HI = 3'd1,
      S_HDR_LO = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            count_hi_q, count_hi_d;
   logic [16:0]           remaining_q, remaining_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [1:0]            idx_q, idx_d;
   logic [31:0]           word_q, word_d;
   logic [16:0]           w_hdr_n;

   // full word count as it will be once the low header byte is taken
   assign w_hdr_n = {1'b0, count_hi_q, bus.rx_data};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         count_hi_q  <= '0;
         remaining_q <= '0;
         addr_q      <= '0;
         idx_q       <= '0;
         word_q      <= '0;
      end else begin
         state_q     <= state_d;
         count_hi_q  <= count_hi_d;
         remaining_q <= remaining_d;
         addr_q      <= addr_d;
         idx_q       <= idx_d;
         word_q      <= word_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      count_hi_d  = count_hi_q;
      remaining_d = remaining_q;
      addr_d      = addr_q;
      idx_d       = idx_q;
      word_d      = word_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) state_d = S_HDR_HI;
         end
         S_HDR_HI: begin
            if (bus.rx_valid) begin
               count_hi_d = bus.rx_data;
               state_d    = S_HDR_LO;
            end
         end
         S_HDR_LO: begin
            if (bus.rx_valid) begin
               if (w_hdr_n == '0) begin
                  state_d = S_DONE;
               end else if (w_hdr_n > c_DEPTH) begin
                  state_d = S_ERR;
               end else begin
                  state_d     = S_DATA;
                  addr_d      = '0;
                  idx_d       = '0;
                  remaining_d = w_hdr_n;
               end
            end
         end
         S_DATA: begin
            if (bus.rx_valid) begin
               word_d = {word_q[23:0], bus.rx_data};
               idx_d  = idx_q + 2'd1;
               if (idx_q == 2'd3) state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            addr_d      = addr_q + ADDR_WIDTH'(1);
            remaining_d = remaining_q - 17'd1;
            state_d     = (remaining_q == 17'd1) ? S_DONE : S_DATA;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // every output is a decode of registered state or a register itself
   assign bus.rx_ready   = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                           (state_q == S_DATA);
   assign bus.imem_we    = (state_q == S_WRITE);
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = word_q;
   assign busy           = bus.rx_ready || (state_q == S_WRITE);
   assign done           = (state_q == S_DONE);
   assign error          = (state_q == S_ERR);
   assign cpu_hold       = (state_q != S_DONE);
endmodule
`default_nettype wire
